// File: rtl/bus_wdt_pkg.sv
// Shared types and CSR offsets for the multi-channel bus watchdog.
package bus_wdt_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StArmed   = 2'd1,
    StTimeout = 2'd2
  } wdt_state_e;

  // CSR offsets relative to the block base address
  localparam int unsigned CtrlOffset     = 0;
  localparam int unsigned StatusOffset   = 1;
  localparam int unsigned IrqEnOffset    = 2;
  localparam int unsigned InfoOffset     = 3;
  localparam int unsigned Timeout0Offset = 4;

endpackage

// File: rtl/bus_wdt_channel.sv
// One watchdog channel: arms on a new request, counts cycles until ack,
// and fires a single registered abort pulse when the budget runs out.
module bus_wdt_channel
  import bus_wdt_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_i,
  input  logic                 req_i,
  input  logic                 ack_i,
  input  logic [CNT_WIDTH-1:0] timeout_i,
  output logic                 fire_o,
  output logic                 abort_o
);

  wdt_state_e           state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 abort_q;

  // Next-state, counter and timeout-fire decode
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fire_o  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (en_i && req_i && !ack_i) begin
          state_d = StArmed;
          cnt_d   = '0;
        end
      end
      StArmed: begin
        if (!en_i) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (ack_i) begin
          // Ack beats a coincident timeout compare
          state_d = StIdle;
          cnt_d   = '0;
        end else if ((timeout_i != '0) && (cnt_q >= timeout_i - CNT_WIDTH'(1))) begin
          state_d = StTimeout;
          fire_o  = 1'b1;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      StTimeout: begin
        // Hold off re-arming until the requester lets go
        if (!req_i) begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter and abort pulse registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      abort_q <= fire_o;
    end
  end

  assign abort_o = abort_q;

endmodule

// File: rtl/bus_watchdog_mc.sv
// Multi-channel bus watchdog: CSR file, sticky timeout status and interrupt,
// with one bus_wdt_channel per monitored requester.
module bus_watchdog_mc
  import bus_wdt_pkg::*;
#(
  parameter int unsigned            NUM_CH      = 4,
  parameter int unsigned            ADDR_WIDTH  = 12,
  parameter int unsigned            DATA_WIDTH  = 32,
  parameter int unsigned            CNT_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR   = 12'hB00,
  parameter int unsigned            RST_TIMEOUT = 1000
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [ADDR_WIDTH-1:0] csr_addr_i,
  input  logic [DATA_WIDTH-1:0] csr_wdata_i,
  input  logic                  csr_write_en_i,
  output logic [DATA_WIDTH-1:0] csr_rdata_o,
  input  logic [NUM_CH-1:0]     ch_req_i,
  input  logic [NUM_CH-1:0]     ch_ack_i,
  output logic [NUM_CH-1:0]     ch_abort_o,
  output logic                  irq_o
);

  if ((NUM_CH < 1) || (NUM_CH > DATA_WIDTH)) begin : gen_bad_num_ch
    $error("NUM_CH must be in 1..DATA_WIDTH");
  end
  if ((CNT_WIDTH < 1) || (CNT_WIDTH > DATA_WIDTH)) begin : gen_bad_cnt_width
    $error("CNT_WIDTH must be in 1..DATA_WIDTH");
  end

  function automatic logic addr_hit(input logic [ADDR_WIDTH-1:0] addr, input int unsigned off);
    return addr == (BASE_ADDR + ADDR_WIDTH'(off));
  endfunction

  logic [NUM_CH-1:0]                ctrl_q, ctrl_d;
  logic [NUM_CH-1:0]                status_q, status_d;
  logic [NUM_CH-1:0]                irq_en_q, irq_en_d;
  logic [NUM_CH-1:0][CNT_WIDTH-1:0] timeout_q, timeout_d;
  logic [NUM_CH-1:0]                fire;
  logic                             unused_wdata;

  // Upper write-data bits have no storage
  assign unused_wdata = ^csr_wdata_i;

  // CSR write decode and sticky status update
  always_comb begin
    ctrl_d    = ctrl_q;
    irq_en_d  = irq_en_q;
    timeout_d = timeout_q;
    status_d  = status_q;
    if (csr_write_en_i) begin
      if (addr_hit(csr_addr_i, CtrlOffset))   ctrl_d   = csr_wdata_i[NUM_CH-1:0];
      if (addr_hit(csr_addr_i, IrqEnOffset))  irq_en_d = csr_wdata_i[NUM_CH-1:0];
      if (addr_hit(csr_addr_i, StatusOffset)) status_d = status_q & ~csr_wdata_i[NUM_CH-1:0];
      for (int i = 0; i < NUM_CH; i++) begin
        if (addr_hit(csr_addr_i, Timeout0Offset + i)) begin
          timeout_d[i] = csr_wdata_i[CNT_WIDTH-1:0];
        end
      end
    end
    // A timeout in the same cycle as a W1C keeps the bit set
    status_d = status_d | fire;
  end

  // CSR and status registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ctrl_q    <= '0;
      status_q  <= '0;
      irq_en_q  <= '0;
      timeout_q <= {NUM_CH{CNT_WIDTH'(RST_TIMEOUT)}};
    end else begin
      ctrl_q    <= ctrl_d;
      status_q  <= status_d;
      irq_en_q  <= irq_en_d;
      timeout_q <= timeout_d;
    end
  end

  // Combinational CSR read mux
  always_comb begin
    csr_rdata_o = '0;
    if (addr_hit(csr_addr_i, CtrlOffset))   csr_rdata_o = DATA_WIDTH'(ctrl_q);
    if (addr_hit(csr_addr_i, StatusOffset)) csr_rdata_o = DATA_WIDTH'(status_q);
    if (addr_hit(csr_addr_i, IrqEnOffset))  csr_rdata_o = DATA_WIDTH'(irq_en_q);
    if (addr_hit(csr_addr_i, InfoOffset))   csr_rdata_o = DATA_WIDTH'(NUM_CH);
    for (int i = 0; i < NUM_CH; i++) begin
      if (addr_hit(csr_addr_i, Timeout0Offset + i)) csr_rdata_o = DATA_WIDTH'(timeout_q[i]);
    end
  end

  assign irq_o = |(status_q & irq_en_q);

  for (genvar g = 0; g < NUM_CH; g++) begin : gen_ch
    bus_wdt_channel #(
      .CNT_WIDTH (CNT_WIDTH)
    ) u_ch (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .en_i      (ctrl_q[g]),
      .req_i     (ch_req_i[g]),
      .ack_i     (ch_ack_i[g]),
      .timeout_i (timeout_q[g]),
      .fire_o    (fire[g]),
      .abort_o   (ch_abort_o[g])
    );
  end

endmodule

// File: tb/tb_bus_watchdog_mc.sv
// Directed bench for bus_watchdog_mc: CSR table plus timing sequences.
module tb_bus_watchdog_mc;

  localparam logic [11:0] Base = 12'hB00;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [11:0] csr_addr_i = '0;
  logic [31:0] csr_wdata_i = '0;
  logic        csr_write_en_i = 1'b0;
  logic [31:0] csr_rdata_o;
  logic [3:0]  ch_req_i = '0;
  logic [3:0]  ch_ack_i = '0;
  logic [3:0]  ch_abort_o;
  logic        irq_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  bus_watchdog_mc dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .csr_addr_i     (csr_addr_i),
    .csr_wdata_i    (csr_wdata_i),
    .csr_write_en_i (csr_write_en_i),
    .csr_rdata_o    (csr_rdata_o),
    .ch_req_i       (ch_req_i),
    .ch_ack_i       (ch_ack_i),
    .ch_abort_o     (ch_abort_o),
    .irq_o          (irq_o)
  );

  typedef struct {
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] exp;
  } csr_vec_t;

  csr_vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance to the negedge following the next active edge
  task automatic tick();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic csr_write(input logic [11:0] addr, input logic [31:0] data);
    csr_addr_i     = addr;
    csr_wdata_i    = data;
    csr_write_en_i = 1'b1;
    tick();
    csr_write_en_i = 1'b0;
  endtask

  task automatic rd_check(input string name, input logic [11:0] addr, input logic [31:0] exp);
    csr_addr_i = addr;
    #1;
    check(name, csr_rdata_o, exp);
  endtask

  initial begin
    int n_abort;

    vecs[0]  = '{Base + 12'd0, 32'h0, 1'b0, 32'd0};
    vecs[1]  = '{Base + 12'd1, 32'h0, 1'b0, 32'd0};
    vecs[2]  = '{Base + 12'd2, 32'h0, 1'b0, 32'd0};
    vecs[3]  = '{Base + 12'd3, 32'h0, 1'b0, 32'd4};
    vecs[4]  = '{Base + 12'd4, 32'h0, 1'b0, 32'd1000};
    vecs[5]  = '{Base + 12'd7, 32'h0, 1'b0, 32'd1000};
    vecs[6]  = '{Base + 12'd8, 32'h0, 1'b0, 32'd0};
    vecs[7]  = '{12'hAFF,      32'h0, 1'b0, 32'd0};
    vecs[8]  = '{Base + 12'd0, 32'hFFFF_FFFF, 1'b1, 32'hF};
    vecs[9]  = '{Base + 12'd2, 32'hFFFF_FFFF, 1'b1, 32'hF};
    vecs[10] = '{Base + 12'd3, 32'h0, 1'b1, 32'd4};
    vecs[11] = '{Base + 12'd8, 32'h55, 1'b1, 32'd0};
    vecs[12] = '{Base + 12'd7, 32'h1234_5678, 1'b1, 32'h1234_5678};
    vecs[13] = '{Base + 12'd1, 32'hF, 1'b1, 32'd0};

    // Reset state
    #1;
    check("rst_abort_during", {28'd0, ch_abort_o}, 32'd0);
    check("rst_irq_during", {31'd0, irq_o}, 32'd0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();
    check("rst_abort_after", {28'd0, ch_abort_o}, 32'd0);
    check("rst_irq_after", {31'd0, irq_o}, 32'd0);

    // CSR table
    for (int i = 0; i < 14; i++) begin
      if (vecs[i].we) csr_write(vecs[i].addr, vecs[i].wdata);
      rd_check($sformatf("csr_vec%0d", i), vecs[i].addr, vecs[i].exp);
    end
    csr_write(Base + 12'd0, 32'h0);
    csr_write(Base + 12'd2, 32'h0);
    csr_write(Base + 12'd7, 32'd1000);

    // Basic timeout on channel 0, T=5
    csr_write(Base + 12'd4, 32'd5);
    csr_write(Base + 12'd0, 32'h1);
    ch_req_i = 4'b0001;
    for (int k = 0; k <= 6; k++) begin
      tick();
      check($sformatf("t5_abort_E%0d", k), {31'd0, ch_abort_o[0]}, {31'd0, k == 5});
    end
    rd_check("t5_status", Base + 12'd1, 32'h1);
    check("t5_irq_masked", {31'd0, irq_o}, 32'd0);
    csr_write(Base + 12'd2, 32'h1);
    check("t5_irq_enabled", {31'd0, irq_o}, 32'd1);
    ch_req_i = 4'b0000;
    tick();
    csr_write(Base + 12'd1, 32'h1);
    check("t5_irq_cleared", {31'd0, irq_o}, 32'd0);

    // Ack at E4 prevents the abort
    ch_req_i = 4'b0001;
    n_abort = 0;
    repeat (4) begin
      tick();
      n_abort += ch_abort_o[0];
    end
    ch_ack_i = 4'b0001;
    tick();
    ch_ack_i = 4'b0000;
    ch_req_i = 4'b0000;
    n_abort += ch_abort_o[0];
    repeat (6) begin
      tick();
      n_abort += ch_abort_o[0];
    end
    check("ack_e4_no_abort", n_abort, 0);

    // Ack coincident with the E5 compare wins
    ch_req_i = 4'b0001;
    n_abort = 0;
    repeat (5) begin
      tick();
      n_abort += ch_abort_o[0];
    end
    ch_ack_i = 4'b0001;
    tick();
    ch_ack_i = 4'b0000;
    ch_req_i = 4'b0000;
    n_abort += ch_abort_o[0];
    tick();
    n_abort += ch_abort_o[0];
    check("ack_e5_no_abort", n_abort, 0);
    rd_check("ack_status", Base + 12'd1, 32'h0);

    // W1C in the same cycle as the timeout: set wins
    ch_req_i = 4'b0001;
    repeat (5) tick();
    csr_write(Base + 12'd1, 32'h1);
    check("w1c_race_abort", {31'd0, ch_abort_o[0]}, 32'd1);
    rd_check("w1c_race_status", Base + 12'd1, 32'h1);
    check("w1c_race_irq", {31'd0, irq_o}, 32'd1);
    ch_req_i = 4'b0000;
    tick();
    csr_write(Base + 12'd1, 32'h1);
    rd_check("w1c_later_status", Base + 12'd1, 32'h0);
    check("w1c_later_irq", {31'd0, irq_o}, 32'd0);

    // TIMEOUT rewritten below the running count fires on the following edge
    csr_write(Base + 12'd4, 32'd100);
    ch_req_i = 4'b0001;
    repeat (10) tick();
    csr_write(Base + 12'd4, 32'd3);
    check("rewrite_abort_E10", {31'd0, ch_abort_o[0]}, 32'd0);
    tick();
    check("rewrite_abort_E11", {31'd0, ch_abort_o[0]}, 32'd1);
    ch_req_i = 4'b0000;
    tick();
    csr_write(Base + 12'd1, 32'h1);
    csr_write(Base + 12'd4, 32'd5);

    // Disable while armed: no abort
    ch_req_i = 4'b0001;
    n_abort = 0;
    repeat (3) begin
      tick();
      n_abort += ch_abort_o[0];
    end
    csr_write(Base + 12'd0, 32'h0);
    n_abort += ch_abort_o[0];
    repeat (6) begin
      tick();
      n_abort += ch_abort_o[0];
    end
    check("disable_no_abort", n_abort, 0);
    rd_check("disable_status", Base + 12'd1, 32'h0);
    ch_req_i = 4'b0000;
    tick();

    // T=0 never times out
    csr_write(Base + 12'd4, 32'd0);
    csr_write(Base + 12'd0, 32'h1);
    ch_req_i = 4'b0001;
    n_abort = 0;
    for (int i = 0; i < 10000; i++) begin
      tick();
      n_abort += ch_abort_o[0];
    end
    check("t0_no_abort", n_abort, 0);
    rd_check("t0_status", Base + 12'd1, 32'h0);
    ch_req_i = 4'b0000;
    tick();

    // All four channels with staggered budgets
    csr_write(Base + 12'd4, 32'd2);
    csr_write(Base + 12'd5, 32'd3);
    csr_write(Base + 12'd6, 32'd4);
    csr_write(Base + 12'd7, 32'd5);
    csr_write(Base + 12'd0, 32'hF);
    ch_req_i = 4'b1111;
    for (int k = 0; k <= 6; k++) begin
      tick();
      check($sformatf("mc_abort_E%0d", k), {28'd0, ch_abort_o},
            (k >= 2 && k <= 5) ? (32'd1 << (k - 2)) : 32'd0);
    end
    rd_check("mc_status", Base + 12'd1, 32'hF);
    check("mc_irq", {31'd0, irq_o}, 32'd1);

    // Asynchronous reset mid-count, while channel 0 is pulsing abort
    ch_req_i = 4'b0000;
    tick();
    ch_req_i = 4'b1111;
    repeat (3) tick();
    check("arst_abort_before", {28'd0, ch_abort_o}, 32'h1);
    #2;
    rst_ni = 1'b0;
    #1;
    check("arst_abort", {28'd0, ch_abort_o}, 32'd0);
    check("arst_irq", {31'd0, irq_o}, 32'd0);
    rd_check("arst_ctrl", Base + 12'd0, 32'd0);
    rd_check("arst_status", Base + 12'd1, 32'd0);
    rd_check("arst_irq_en", Base + 12'd2, 32'd0);
    rd_check("arst_timeout0", Base + 12'd4, 32'd1000);
    rd_check("arst_timeout3", Base + 12'd7, 32'd1000);
    @(negedge clk_i);
    rst_ni = 1'b1;
    n_abort = 0;
    repeat (5) begin
      tick();
      n_abort += (ch_abort_o != 4'd0);
    end
    check("arst_quiet_after", n_abort, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
